ps2_device_tx: RTL

- Device-side PS/2 transmitter: emulates a keyboard or mouse sending bytes to a PS/2 host.
- Generates PS/2 clock and data as open-drain pull-low enables.
- Frames each byte as start, 8 data bits LSB first, odd parity and stop.
- Honours host inhibit (host holding clock low); aborted bytes are retried.
- Used for synthetic scancode injection (e.g. an on-screen keyboard or joystick-to-key mapper) feeding the host-side ps2 receiver, and as a loopback source for bench verification.

---
 rtl/ps2_device_tx.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: frames bytes (start, 8 data LSB first, odd parity, stop)
// onto open-drain clock/data enables, honouring host inhibit. Define PS2DEV_FIFO_EN for a 4-deep queue.
module ps2_device_tx #(
  parameter int CLKFREQ = 28000000,
  parameter int PS2FREQ = 12500,
  parameter int IDLEUS  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       host_rts
);
  localparam logic [15:0] HALF = 16'(CLKFREQ / (2 * PS2FREQ));
  localparam logic [15:0] IDLE = 16'(CLKFREQ / 1000000 * IDLEUS);
  localparam logic [15:0] RISE = 16'd16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAITIDLE = 3'd1;
  localparam logic [2:0] ST_SENDHI   = 3'd2;
  localparam logic [2:0] ST_SENDLO   = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_s, data_s;
  logic [2:0]  state_q, state_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_abort_q, tx_abort_d;
  logic        host_rts_q, host_rts_d;
  logic        have_byte;
  logic [7:0]  head;
  logic        accept;
  logic        consume;

  // Lines idle high, so the synchronisers come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk_ext};
      data_sync_q <= {data_sync_q[0], ps2data_ext};
    end
  end

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign accept  = tx_valid && tx_ready;
  assign consume = (state_q == ST_FINISH);

`ifdef PS2DEV_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  assign have_byte = (count_q != 3'd0);
  assign tx_ready  = (count_q != 3'd4);
  assign head      = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 2'd1;
    if (consume) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({accept, consume})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_q] <= tx_data;
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  assign have_byte = full_q;
  assign tx_ready  = !full_q;
  assign head      = hold_q;

  // Cleared only when a frame completes; an abort keeps the byte for retry.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (consume) full_d = 1'b0;
    if (accept) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic r;
    r = b[idx[2:0] - 3'd1];
    if (idx == 4'd0) r = 1'b0;
    else if (idx == 4'd9) r = ~^b;
    else if (idx == 4'd10) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    idle_cnt_d = idle_cnt_q;
    bit_idx_d  = bit_idx_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_abort_d = 1'b0;
    host_rts_d = ((state_q == ST_IDLE) || (state_q == ST_WAITIDLE)) && clk_s && !data_s;
    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (have_byte) begin
          state_d    = ST_WAITIDLE;
          idle_cnt_d = 16'd0;
        end
      end
      ST_WAITIDLE: begin
        if (clk_s && data_s) begin
          if (idle_cnt_q == IDLE - 16'd1) begin
            state_d    = ST_SENDHI;
            bit_idx_d  = 4'd0;
            half_cnt_d = 16'd0;
            clk_oe_d   = 1'b0;
            data_oe_d  = ~frame_bit(head, 4'd0);
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end else begin
          idle_cnt_d = 16'd0;
        end
      end
      ST_SENDHI: begin
        // Clock low after the rise-time window means the host is inhibiting.
        if (half_cnt_q >= RISE && !clk_s) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          half_cnt_d = 16'd0;
          if (bit_idx_q == 4'd10) begin
            state_d   = ST_FINISH;
            tx_done_d = 1'b1;
          end else begin
            state_d    = ST_WAITIDLE;
            idle_cnt_d = 16'd0;
            tx_abort_d = 1'b1;
          end
        end else if (half_cnt_q == HALF - 16'd1) begin
          state_d    = ST_SENDLO;
          half_cnt_d = 16'd0;
          clk_oe_d   = 1'b1;
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
      end
      ST_SENDLO: begin
        if (half_cnt_q == HALF - 16'd1) begin
          half_cnt_d = 16'd0;
          clk_oe_d   = 1'b0;
          if (bit_idx_q == 4'd10) begin
            state_d   = ST_FINISH;
            data_oe_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            state_d   = ST_SENDHI;
            bit_idx_d = bit_idx_q + 4'd1;
            data_oe_d = ~frame_bit(head, bit_idx_q + 4'd1);
          end
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      half_cnt_q <= 16'd0;
      idle_cnt_q <= 16'd0;
      bit_idx_q  <= 4'd0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      host_rts_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      bit_idx_q  <= bit_idx_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_abort_q <= tx_abort_d;
      host_rts_q <= host_rts_d;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign tx_done    = tx_done_q;
  assign tx_abort   = tx_abort_q;
  assign host_rts   = host_rts_q;
  assign busy       = (state_q != ST_IDLE) || have_byte;

endmodule
